// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster/test-pattern block: mode codes, default
// 800x600@60 timing (40 MHz pixel clock), colour widths and the colour-bar table.
// No logic of its own; latency and backpressure do not apply.
package vga_pkg;

    // Default 800x600@60 timing
    localparam int H_ACTIVE_DEF = 800;
    localparam int H_FP_DEF     = 40;
    localparam int H_SYNC_DEF   = 128;
    localparam int H_BP_DEF     = 88;
    localparam int V_ACTIVE_DEF = 600;
    localparam int V_FP_DEF     = 1;
    localparam int V_SYNC_DEF   = 4;
    localparam int V_BP_DEF     = 23;

    localparam int CW_DEF = 4;   // bits per colour channel (12-bit DVI PMOD)
    localparam int XW_DEF = 11;
    localparam int YW_DEF = 10;

    typedef enum logic [1:0] {
        MODE_BARS     = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_SOLID    = 2'd3
    } mode_e;

    // Bar colours left to right as {r,g,b} on/off flags: W,Y,C,G,M,R,B,K
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] c;
        case (idx)
            3'd0:    c = 3'b111;
            3'd1:    c = 3'b110;
            3'd2:    c = 3'b011;
            3'd3:    c = 3'b010;
            3'd4:    c = 3'b101;
            3'd5:    c = 3'b100;
            3'd6:    c = 3'b001;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Raster counters hc/vc with decoded active/hs/vs flags and frame-start strobe.
// Flags are combinational from the counter registers (zero cycles); the caller registers them.
// No backpressure: free-running while enable_i=1, parked at (0,0) while enable_i=0.
//
// Ports: clk, reset_n (async, active low), enable_i; hc_o/vc_o raster position;
//        active_o, hs_o, vs_o (polarity applied), frame_start_o (high at (0,0)).
//        All flags are forced to their idle values while enable_i=0.
module video_timing_counter #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int XW       = 11,
    parameter int YW       = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable_i,
    output logic [XW-1:0] hc_o,
    output logic [YW-1:0] vc_o,
    output logic          active_o,
    output logic          hs_o,
    output logic          vs_o,
    output logic          frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [XW-1:0] hc_q, hc_d;
    logic [YW-1:0] vc_q, vc_d;
    logic          in_hs, in_vs;

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (!enable_i) begin
            hc_d = '0;
            vc_d = '0;
        end else if (hc_q == XW'(H_TOTAL - 1)) begin
            hc_d = '0;
            vc_d = (vc_q == YW'(V_TOTAL - 1)) ? '0 : vc_q + YW'(1);
        end else begin
            hc_d = hc_q + XW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    // vs depends on vc only, so it naturally switches at hc=0
    assign in_hs = (hc_q >= XW'(H_ACTIVE + H_FP)) && (hc_q < XW'(H_ACTIVE + H_FP + H_SYNC));
    assign in_vs = (vc_q >= YW'(V_ACTIVE + V_FP)) && (vc_q < YW'(V_ACTIVE + V_FP + V_SYNC));

    assign hc_o          = hc_q;
    assign vc_o          = vc_q;
    assign active_o      = enable_i && (hc_q < XW'(H_ACTIVE)) && (vc_q < YW'(V_ACTIVE));
    assign hs_o          = (enable_i && in_hs) ? HS_POL : ~HS_POL;
    assign vs_o          = (enable_i && in_vs) ? VS_POL : ~VS_POL;
    assign frame_start_o = enable_i && (hc_q == '0) && (vc_q == '0);

endmodule

// File: rtl/vga_pattern_generator.sv
// Raster timing generator plus test-pattern source (bars/checker/gradient/white) for a 12-bit DVI PMOD.
// Latency: one register stage from raster counters to every output; all outputs aligned.
// No backpressure: pixel stream is free-running; i_enable=0 parks the raster at idle.
//
// Ports: clk, reset_n (async, active low), i_enable, i_mode[1:0];
//        o_r/o_g/o_b[CW], o_hs, o_vs, o_de, o_x[XW], o_y[YW], o_frame_start, o_frame_count[8].
// Build option: define PATTERN_SCROLL_EN to scroll the pattern x coordinate by o_frame_count.
module vga_pattern_generator
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CW       = CW_DEF,
    parameter int XW       = XW_DEF,
    parameter int YW       = YW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_enable,
    input  logic [1:0]    i_mode,
    output logic [CW-1:0] o_r,
    output logic [CW-1:0] o_g,
    output logic [CW-1:0] o_b,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_de,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_frame_start,
    output logic [7:0]    o_frame_count
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [XW-1:0] hc;
    logic [YW-1:0] vc;
    logic          active, hs, vs, frame_start;

    video_timing_counter #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HS_POL   (HS_POL),   .VS_POL (VS_POL), .XW (XW), .YW (YW)
    ) u_timing (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable_i      (i_enable),
        .hc_o          (hc),
        .vc_o          (vc),
        .active_o      (active),
        .hs_o          (hs),
        .vs_o          (vs),
        .frame_start_o (frame_start)
    );

    mode_e         mode_q, mode_d;
    logic [7:0]    frame_count_q, frame_count_d;
    logic          seen_frame_q, seen_frame_d;
    logic [XW-1:0] px;
    logic [XW-1:0] bar_idx_full;
    logic [2:0]    bar_idx;
    logic [2:0]    bar_col;
    logic [CW-1:0] r_d, g_d, b_d;
    logic [CW-1:0] r_q, g_q, b_q;
    logic          hs_q, vs_q, de_q, fs_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;

    // The _d values are used for the pattern so that the frame-start pixel
    // already shows the new mode and the new frame count.
    always_comb begin
        mode_d        = mode_q;
        frame_count_d = frame_count_q;
        seen_frame_d  = seen_frame_q;
        if ((hc == '0) && (vc == '0)) begin
            mode_d = mode_e'(i_mode);
        end
        // The first frame after reset keeps count 0; later frame starts advance it.
        if (frame_start) begin
            seen_frame_d = 1'b1;
            if (seen_frame_q) begin
                frame_count_d = frame_count_q + 8'd1;
            end
        end
    end

`ifdef PATTERN_SCROLL_EN
    logic [XW+8:0] px_sum;
    assign px_sum = (XW+9)'(hc) + (XW+9)'(frame_count_d);
    assign px     = XW'(px_sum % (XW+9)'(H_ACTIVE));
`else
    assign px = hc;
`endif

    // A remainder beyond 8 whole bars belongs to the last (black) bar
    assign bar_idx_full = px / XW'(BAR_W);
    assign bar_idx      = (bar_idx_full > XW'(7)) ? 3'd7 : bar_idx_full[2:0];
    assign bar_col      = bar_rgb(bar_idx);

    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (active) begin
            case (mode_d)
                MODE_BARS: begin
                    r_d = {CW{bar_col[2]}};
                    g_d = {CW{bar_col[1]}};
                    b_d = {CW{bar_col[0]}};
                end
                MODE_CHECKER: begin
                    r_d = {CW{px[5] ^ vc[5]}};
                    g_d = {CW{px[5] ^ vc[5]}};
                    b_d = {CW{px[5] ^ vc[5]}};
                end
                MODE_GRADIENT: begin
                    r_d = CW'(px >> 4);
                    g_d = CW'(vc >> 4);
                    b_d = CW'((px + XW'(vc)) >> 4);
                end
                default: begin
                    r_d = '1;
                    g_d = '1;
                    b_d = '1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q        <= MODE_BARS;
            frame_count_q <= 8'd0;
            seen_frame_q  <= 1'b0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            de_q          <= 1'b0;
            fs_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
        end else begin
            mode_q        <= mode_d;
            frame_count_q <= frame_count_d;
            seen_frame_q  <= seen_frame_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            hs_q          <= hs;
            vs_q          <= vs;
            de_q          <= active;
            fs_q          <= frame_start;
            // Counters may still hold a mid-line value on the cycle enable drops
            x_q           <= i_enable ? hc : '0;
            y_q           <= i_enable ? vc : '0;
        end
    end

    assign o_r           = r_q;
    assign o_g           = g_q;
    assign o_b           = b_q;
    assign o_hs          = hs_q;
    assign o_vs          = vs_q;
    assign o_de          = de_q;
    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_frame_start = fs_q;
    assign o_frame_count = frame_count_q;

endmodule
